// File: rtl/ls_pkg.sv
// Shared constants for the load/store controller: opcodes, ALU select,
// FSM state encoding and instruction field layout.
package ls_pkg;

  localparam int OP_W = 4;
  localparam int RSV_W = 2;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LW  = 4'h1;
  localparam logic [OP_W-1:0] OP_SW  = 4'h2;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // Field positions, LSB first: offset, reserved, rt, rs, opcode.
  localparam int OFF_LSB = 0;

  function automatic int rsv_lsb(input int off_w);
    return OFF_LSB + off_w;
  endfunction

  function automatic int rt_lsb(input int off_w);
    return rsv_lsb(off_w) + RSV_W;
  endfunction

  function automatic int rs_lsb(input int reg_aw, input int off_w);
    return rt_lsb(off_w) + reg_aw;
  endfunction

  function automatic int op_lsb(input int reg_aw, input int off_w);
    return rs_lsb(reg_aw, off_w) + reg_aw;
  endfunction

endpackage

// File: rtl/ls_decode.sv
// Combinational opcode classifier for the load/store controller.
module ls_decode
  import ls_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output logic            is_lw,
  output logic            is_sw,
  output logic            is_nop,
  output logic            is_illegal
);

  // One-hot opcode class; anything undefined is flagged illegal.
  always_comb begin
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_nop     = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_NOP:  is_nop     = 1'b1;
      OP_LW:   is_lw      = 1'b1;
      OP_SW:   is_sw      = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ls_controller.sv
// Load/store control FSM (IDLE/DECODE/EXEC/MEM/WB) with registered datapath controls.
// Optional retire/stall counters are enabled by defining LS_CTRL_PERF_CNT_EN.
module ls_controller
  import ls_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int OFF_W  = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [OP_W+2*REG_AW+RSV_W+OFF_W-1:0] instr,
  input  logic                                instr_valid,
  output logic                                instr_ready,
  input  logic                                mem_wait,
  output logic [REG_AW-1:0]                   rs,
  output logic [REG_AW-1:0]                   rt,
  output logic [OFF_W-1:0]                    offset,
  output logic [3:0]                          ALU_Sel,
  output logic                                MemRead,
  output logic                                MemWrite,
  output logic                                RegWrite,
  output logic                                done,
  output logic                                illegal
`ifdef LS_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]                         retired_cnt,
  output logic [15:0]                         stall_cnt
`endif
);

  localparam int RSV_LSB = rsv_lsb(OFF_W);
  localparam int RT_LSB  = rt_lsb(OFF_W);
  localparam int RS_LSB  = rs_lsb(REG_AW, OFF_W);
  localparam int OP_LSB  = op_lsb(REG_AW, OFF_W);

  state_e              state_r;
  state_e              state_next_s;
  logic [OP_W-1:0]     op_r;
  logic [OP_W-1:0]     op_next_s;
  logic [REG_AW-1:0]   rs_r;
  logic [REG_AW-1:0]   rt_r;
  logic [OFF_W-1:0]    offset_r;
  logic [3:0]          alu_sel_r;
  logic                instr_ready_r;
  logic                memread_r;
  logic                memwrite_r;
  logic                regwrite_r;
  logic                done_r;
  logic                illegal_r;
  logic                accept_s;
  logic                is_lw_s;
  logic                is_sw_s;
  logic                is_nop_s;
  logic                is_illegal_s;
  logic                rsv_unused_s;

  assign rsv_unused_s = ^instr[RSV_LSB +: RSV_W];

  assign accept_s  = (state_r == ST_IDLE) && instr_valid && instr_ready_r;
  // The decoder sees the incoming opcode on accept so flags can be registered for DECODE.
  assign op_next_s = accept_s ? instr[OP_LSB +: OP_W] : op_r;

  ls_decode u_decode (
    .opcode     (op_next_s),
    .is_lw      (is_lw_s),
    .is_sw      (is_sw_s),
    .is_nop     (is_nop_s),
    .is_illegal (is_illegal_s)
  );

  // Next-state selection.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_next_s = ST_DECODE;
        else          state_next_s = ST_IDLE;
      end
      ST_DECODE: begin
        if (is_lw_s || is_sw_s) state_next_s = ST_EXEC;
        else                    state_next_s = ST_IDLE;
      end
      ST_EXEC: state_next_s = ST_MEM;
      ST_MEM: begin
        if (mem_wait)     state_next_s = ST_MEM;
        else if (is_lw_s) state_next_s = ST_WB;
        else              state_next_s = ST_IDLE;
      end
      ST_WB:   state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, captured fields and controls, all registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      op_r          <= OP_NOP;
      rs_r          <= '0;
      rt_r          <= '0;
      offset_r      <= '0;
      alu_sel_r     <= 4'b0000;
      instr_ready_r <= 1'b1;
      memread_r     <= 1'b0;
      memwrite_r    <= 1'b0;
      regwrite_r    <= 1'b0;
      done_r        <= 1'b0;
      illegal_r     <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        op_r     <= instr[OP_LSB +: OP_W];
        rs_r     <= instr[RS_LSB +: REG_AW];
        rt_r     <= instr[RT_LSB +: REG_AW];
        offset_r <= instr[OFF_LSB +: OFF_W];
      end
      alu_sel_r     <= ALU_ADD;
      instr_ready_r <= (state_next_s == ST_IDLE);
      memread_r     <= (state_next_s == ST_MEM) && is_lw_s;
      memwrite_r    <= (state_next_s == ST_MEM) && is_sw_s;
      regwrite_r    <= (state_next_s == ST_WB);
      done_r        <= (state_next_s == ST_WB) ||
                       ((state_next_s == ST_DECODE) && (is_nop_s || is_illegal_s));
      illegal_r     <= (state_next_s == ST_DECODE) && is_illegal_s;
    end
  end

  assign instr_ready = instr_ready_r;
  assign rs          = rs_r;
  assign rt          = rt_r;
  assign offset      = offset_r;
  assign ALU_Sel     = alu_sel_r;
  assign MemRead     = memread_r;
  assign MemWrite    = memwrite_r;
  assign RegWrite    = regwrite_r;
  assign illegal     = illegal_r;
  // SW retires in the MEM cycle the stall lifts; suppressed while reset is asserted.
  assign done        = done_r | (memwrite_r & ~mem_wait & rst_n);

`ifdef LS_CTRL_PERF_CNT_EN
  logic [15:0] retired_cnt_r;
  logic [15:0] stall_cnt_r;

  // Retire counter wraps; stall counter saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_cnt_r <= 16'h0000;
      stall_cnt_r   <= 16'h0000;
    end else begin
      if (done) retired_cnt_r <= retired_cnt_r + 16'h0001;
      if ((state_r == ST_MEM) && mem_wait && (stall_cnt_r != 16'hFFFF))
        stall_cnt_r <= stall_cnt_r + 16'h0001;
    end
  end

  assign retired_cnt = retired_cnt_r;
  assign stall_cnt   = stall_cnt_r;
`else
  // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_ls_controller.sv
// Directed self-checking bench for ls_controller.
module tb_ls_controller;

  logic        clk;
  logic        rst_n;
  logic [23:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        mem_wait;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [7:0]  offset;
  logic [3:0]  ALU_Sel;
  logic        MemRead;
  logic        MemWrite;
  logic        RegWrite;
  logic        done;
  logic        illegal;
`ifdef LS_CTRL_PERF_CNT_EN
  logic [15:0] retired_cnt;
  logic [15:0] stall_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;

  // LW: op=1 rs=0x10 rt=0x11 off=0x04
  localparam logic [23:0] LW_A = 24'h184404;
  // SW: op=2 rs=0x03 rt=0x05 reserved=2'b11 off=0x20
  localparam logic [23:0] SW_B = 24'h219720;

  ls_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .mem_wait    (mem_wait),
    .rs          (rs),
    .rt          (rt),
    .offset      (offset),
    .ALU_Sel     (ALU_Sel),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .RegWrite    (RegWrite),
    .done        (done),
    .illegal     (illegal)
`ifdef LS_CTRL_PERF_CNT_EN
    ,
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction end to end, finishing in IDLE.
  task automatic run_ls(input logic [23:0] w, input int stalls);
    instr = w; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    mem_wait = (stalls > 0);
    step();
    repeat (stalls) step();
    mem_wait = 1'b0;
    step();
    if (w[23:20] == 4'h1) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; instr = 24'h000000; instr_valid = 1'b0; mem_wait = 1'b0;
    step(); step();
    check_eq("rst_ready", instr_ready, 1);
    check_eq("rst_rs", rs, 0);
    check_eq("rst_rt", rt, 0);
    check_eq("rst_off", offset, 0);
    check_eq("rst_alu", ALU_Sel, 0);
    check_eq("rst_strobes", {MemRead, MemWrite, RegWrite, done, illegal}, 0);
    rst_n = 1'b1;
    step();
    check_eq("idle_ready", instr_ready, 1);

    // LW without stall
    instr = LW_A; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    check_eq("lw_k1_ready", instr_ready, 0);
    check_eq("lw_k1_rs", rs, 32'h10);
    check_eq("lw_k1_rt", rt, 32'h11);
    check_eq("lw_k1_off", offset, 32'h04);
    check_eq("lw_k1_done", done, 0);
    step();
    check_eq("lw_k2_memread", MemRead, 0);
    check_eq("lw_k2_rs", rs, 32'h10);
    check_eq("lw_k2_off", offset, 32'h04);
    step();
    check_eq("lw_k3_memread", MemRead, 1);
    check_eq("lw_k3_memwrite", MemWrite, 0);
    check_eq("lw_k3_regwrite", RegWrite, 0);
    check_eq("lw_k3_done", done, 0);
    check_eq("lw_k3_rs_off", {rs, offset}, {5'h10, 8'h04});
    step();
    check_eq("lw_k4_regwrite", RegWrite, 1);
    check_eq("lw_k4_done", done, 1);
    check_eq("lw_k4_memread", MemRead, 0);
    check_eq("lw_k4_rs_off", {rs, offset}, {5'h10, 8'h04});
    check_eq("lw_k4_alu", ALU_Sel, 0);
    step();
    check_eq("lw_k5_ready", instr_ready, 1);
    check_eq("lw_k5_done", done, 0);
    check_eq("lw_k5_regwrite", RegWrite, 0);
    check_eq("lw_k5_rs_hold", rs, 32'h10);

    // SW with two stall cycles
    instr = SW_B; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    check_eq("sw_fields", {rs, rt, offset}, {5'h03, 5'h05, 8'h20});
    check_eq("sw_k1_done", done, 0);
    step();
    mem_wait = 1'b1; #1;
    check_eq("sw_exec_memwrite", MemWrite, 0);
    step();
    check_eq("sw_st1_memwrite", MemWrite, 1);
    check_eq("sw_st1_done", done, 0);
    check_eq("sw_st1_regwrite", RegWrite, 0);
    check_eq("sw_st1_memread", MemRead, 0);
    step();
    check_eq("sw_st2_memwrite", MemWrite, 1);
    check_eq("sw_st2_done", done, 0);
    step();
    mem_wait = 1'b0; #1;
    check_eq("sw_last_memwrite", MemWrite, 1);
    check_eq("sw_last_done", done, 1);
    check_eq("sw_last_regwrite", RegWrite, 0);
    step();
    check_eq("sw_idle_memwrite", MemWrite, 0);
    check_eq("sw_idle_done", done, 0);
    check_eq("sw_idle_ready", instr_ready, 1);

    // Illegal opcode 4'hF
    instr = 24'hF00000; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    check_eq("ill_k1_illegal", illegal, 1);
    check_eq("ill_k1_done", done, 1);
    check_eq("ill_k1_strobes", {MemRead, MemWrite, RegWrite}, 0);
    check_eq("ill_k1_ready", instr_ready, 0);
    step();
    check_eq("ill_k2_ready", instr_ready, 1);
    check_eq("ill_k2_flags", {illegal, done}, 0);

    // NOP
    instr = 24'h000000; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    check_eq("nop_k1_done_ill", {done, illegal}, 2'b10);
    step();
    check_eq("nop_k2_ready", instr_ready, 1);

    // instr_valid held high across a LW: single accept, next at k+5
    instr = LW_A; instr_valid = 1'b1;
    step();
    instr = SW_B;
    step();
    check_eq("hold_k2_ready", instr_ready, 0);
    step(); step();
    check_eq("hold_k4_lw_retire", {done, RegWrite}, 2'b11);
    check_eq("hold_k4_rt", rt, 32'h11);
    step();
    check_eq("hold_k5_ready", instr_ready, 1);
    check_eq("hold_k5_rt", rt, 32'h11);
    step(); instr_valid = 1'b0;
    check_eq("hold_k6_ready", instr_ready, 0);
    check_eq("hold_k6_rt", rt, 32'h05);
    step(); step();
    check_eq("hold_sw_mem", {MemWrite, done}, 2'b11);
    step();
    check_eq("hold_sw_idle", instr_ready, 1);

    // Reset during stalled MEM of a LW
    instr = LW_A; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    step();
    mem_wait = 1'b1;
    step();
    check_eq("rstmem_memread", MemRead, 1);
    step();
    rst_n = 1'b0; mem_wait = 1'b0; #1;
    check_eq("rstmem_done_gated", done, 0);
    step();
    check_eq("rstmem_ready", instr_ready, 1);
    check_eq("rstmem_strobes", {MemRead, MemWrite, RegWrite, done}, 0);
    check_eq("rstmem_rs", rs, 0);
    rst_n = 1'b1;
    step();
    check_eq("rstmem_after", {done, RegWrite, instr_ready}, 3'b001);

`ifdef LS_CTRL_PERF_CNT_EN
    check_eq("perf_rst_retired", retired_cnt, 0);
    check_eq("perf_rst_stall", stall_cnt, 0);
    run_ls(LW_A, 0);
    run_ls(LW_A, 0);
    run_ls(LW_A, 0);
    run_ls(SW_B, 2);
    check_eq("perf_retired", retired_cnt, 4);
    check_eq("perf_stall", stall_cnt, 2);
`else
    run_ls(SW_B, 1);
    check_eq("tail_sw_idle", {instr_ready, MemWrite}, 2'b10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
